// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - FIFO-buffered UART transmitter with parity, stop-bit options and back-to-back frames
module uart_tx_stream #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 4000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          uart_clock,
  input  logic                          uart_reset,
  input  logic                          uart_tx_enable,
  input  logic                          uart_tx_valid,
  input  logic [DATA_BITS-1:0]          uart_tx_data,
  output logic                          uart_tx_ready,
  output logic                          uart_d_out,
  output logic                          uart_busy,
  output logic                          uart_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   uart_fifo_level
);

  localparam int DIVISOR = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIVISOR - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic             PAR_ODD   = 1'(PARITY_MODE == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 push, pop, can_pop;
  logic [DATA_BITS-1:0] fifo_head;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 d_out_q, line_d;
  logic                 bit_end;

  assign uart_tx_ready   = (level_q != LVL_FULL);
  assign uart_fifo_level = level_q;
  assign push            = uart_tx_valid && uart_tx_ready;
  assign can_pop         = uart_tx_enable && (level_q != '0);
  assign fifo_head       = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; pointers and level define which entries are live.
  always_ff @(posedge uart_clock) begin
    if (push) mem_q[wr_ptr_q] <= uart_tx_data;
  end

  always_ff @(posedge uart_clock) begin
    if (!uart_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign bit_end      = (cnt_q == CNT_MAX);
  assign uart_busy    = (state_q != S_IDLE);
  assign uart_tx_done = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
  assign uart_d_out   = d_out_q;

  // line_d is the level the line takes after this edge, so the output is registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    line_d   = d_out_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        line_d = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          state_d = S_START;
          line_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          line_d  = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != 0) begin
              state_d = S_PARITY;
              line_d  = parity_q;
            end else begin
              state_d = S_STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            line_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          line_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (can_pop) begin
              pop     = 1'b1;
              state_d = S_START;
              line_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
              line_d  = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        line_d  = 1'b1;
      end
    endcase
    if (pop) begin
      shift_d  = fifo_head;
      parity_d = (^fifo_head) ^ PAR_ODD;
    end
  end

  always_ff @(posedge uart_clock) begin
    if (!uart_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      d_out_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      d_out_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - four transmitter configurations checked against a frame-level model
module tb_uart_tx_stream;

  logic        clk;
  logic        rstn;
  logic [3:0]  en, vld;
  logic [8:0]  data [4];
  logic [3:0]  rdy, dout, busy, done;
  logic [15:0] lvlv;
  logic [2:0]  lvl3;

  int total = 0;
  int bad   = 0;

  assign lvlv[15:12] = {1'b0, lvl3};

  uart_tx_stream #(.CLOCK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(0),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u0 (
    .uart_clock(clk), .uart_reset(rstn), .uart_tx_enable(en[0]), .uart_tx_valid(vld[0]),
    .uart_tx_data(data[0][7:0]), .uart_tx_ready(rdy[0]), .uart_d_out(dout[0]),
    .uart_busy(busy[0]), .uart_tx_done(done[0]), .uart_fifo_level(lvlv[3:0]));

  uart_tx_stream #(.CLOCK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(2),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u1 (
    .uart_clock(clk), .uart_reset(rstn), .uart_tx_enable(en[1]), .uart_tx_valid(vld[1]),
    .uart_tx_data(data[1][7:0]), .uart_tx_ready(rdy[1]), .uart_d_out(dout[1]),
    .uart_busy(busy[1]), .uart_tx_done(done[1]), .uart_fifo_level(lvlv[7:4]));

  uart_tx_stream #(.CLOCK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_MODE(1),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u2 (
    .uart_clock(clk), .uart_reset(rstn), .uart_tx_enable(en[2]), .uart_tx_valid(vld[2]),
    .uart_tx_data(data[2][7:0]), .uart_tx_ready(rdy[2]), .uart_d_out(dout[2]),
    .uart_busy(busy[2]), .uart_tx_done(done[2]), .uart_fifo_level(lvlv[11:8]));

  uart_tx_stream #(.CLOCK_FREQ(40), .BAUD_RATE(10), .DATA_BITS(7), .PARITY_MODE(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .uart_clock(clk), .uart_reset(rstn), .uart_tx_enable(en[3]), .uart_tx_valid(vld[3]),
    .uart_tx_data(data[3][6:0]), .uart_tx_ready(rdy[3]), .uart_d_out(dout[3]),
    .uart_busy(busy[3]), .uart_tx_done(done[3]), .uart_fifo_level(lvl3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int db(input int i);  return (i == 3) ? 7 : 8; endfunction
  function automatic int par(input int i); return (i == 1) ? 2 : ((i == 2) ? 1 : 0); endfunction
  function automatic int sb(input int i);  return (i == 3) ? 2 : 1; endfunction
  function automatic int dep(input int i); return (i == 3) ? 4 : 8; endfunction
  function automatic logic [3:0] lv(input int i); return lvlv[i*4 +: 4]; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a circular list, each frame as a symbol list held 4 cycles per symbol
  int         mq [4][16];
  int         mh [4], mc [4], rem [4], fl [4];
  bit         sym [4][16];
  logic [8:0] rxw [4];
  logic [8:0] rxl [4][32];
  int         rxn [4];
  bit         run = 1'b0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      mh[i] = 0; mc[i] = 0; rem[i] = 0; fl[i] = 0; rxn[i] = 0; rxw[i] = '0;
    end
    forever begin
      @(posedge clk);
      if (!rstn) begin
        for (int i = 0; i < 4; i++) begin mh[i] = 0; mc[i] = 0; rem[i] = 0; end
        run = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          bit acc;
          acc = vld[i] && (mc[i] != dep(i));
          if (en[i] && mc[i] > 0 && rem[i] <= 1) begin
            int w, p, ns;
            w = mq[i][mh[i]];
            mh[i] = (mh[i] + 1) % 16;
            mc[i] = mc[i] - 1;
            p = 0;
            sym[i][0] = 1'b0;
            for (int b = 0; b < db(i); b++) begin
              sym[i][1+b] = w[b];
              p = p ^ w[b];
            end
            ns = 1 + db(i);
            if (par(i) != 0) begin
              sym[i][ns] = (par(i) == 2) ? p[0] : ~p[0];
              ns++;
            end
            for (int s = 0; s < sb(i); s++) sym[i][ns+s] = 1'b1;
            ns = ns + sb(i);
            fl[i]  = ns * 4;
            rem[i] = fl[i];
          end else if (rem[i] > 0) begin
            rem[i] = rem[i] - 1;
          end
          if (acc) begin
            mq[i][(mh[i] + mc[i]) % 16] = int'(data[i]) & ((1 << db(i)) - 1);
            mc[i] = mc[i] + 1;
          end
        end
      end
    end
  end

  // Per-cycle compare plus a mid-symbol receiver that logs decoded words from the DUT line
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        for (int i = 0; i < 4; i++) begin
          int pos, s;
          logic e_line;
          pos = fl[i] - rem[i];
          s   = pos / 4;
          e_line = (rem[i] > 0) ? sym[i][s] : 1'b1;
          chk($sformatf("line%0d", i),  dout[i], e_line);
          chk($sformatf("busy%0d", i),  busy[i], rem[i] > 0);
          chk($sformatf("done%0d", i),  done[i], rem[i] == 1);
          chk($sformatf("level%0d", i), lv(i), mc[i]);
          chk($sformatf("ready%0d", i), rdy[i], mc[i] != dep(i));
          if (rem[i] > 0 && (pos % 4) == 2 && s >= 1 && s <= db(i)) rxw[i][s-1] = dout[i];
          if (rem[i] == 1) begin
            rxl[i][rxn[i]] = rxw[i];
            rxn[i] = rxn[i] + 1;
            rxw[i] = '0;
          end
        end
      end
    end
  end

  task automatic put(input int i, input logic [8:0] w);
    @(negedge clk);
    vld[i]  = 1'b1;
    data[i] = w;
    @(negedge clk);
    vld[i]  = 1'b0;
  endtask

  task automatic wait_drain(input int i, input int budget);
    int c = 0;
    while ((busy[i] !== 1'b0 || lv(i) != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_busy", busy[i], 0);
    chk("drain_level", lv(i), 0);
  endtask

  initial begin
    logic [9:0] f_a5;
    logic [8:0] w3 [6];
    logic [8:0] w6 [5];
    int n, c, base;
    logic r;
    f_a5 = 10'b1101001010;
    w3 = '{9'h55, 9'h2A, 9'h7F, 9'h01, 9'h40, 9'h33};
    w6 = '{9'hA1, 9'hB2, 9'hC3, 9'hD4, 9'hE5};
    rstn = 1'b0;
    en   = 4'hF;
    vld  = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_line", dout[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_level", lv(0), 0);
    chk("rst_ready", rdy[0], 1);
    rstn = 1'b1;

    // 8N1, 0xA5
    put(0, 9'h0A5);
    chk("t1_pre_level", lv(0), 1);
    chk("t1_pre_line", dout[0], 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk("t1_busy", busy[0], 1);
      if ((k % 4) == 2) chk($sformatf("t1_sym%0d", (k-1)/4), dout[0], f_a5[(k-1)/4]);
      if (k == 39) chk("t1_done39", done[0], 0);
      if (k == 40) chk("t1_done40", done[0], 1);
    end
    @(negedge clk);
    chk("t1_busy_fall", busy[0], 0);

    // 8E1 and 8O1, 0x07
    @(negedge clk);
    vld[1] = 1'b1; vld[2] = 1'b1; data[1] = 9'h007; data[2] = 9'h007;
    @(negedge clk);
    vld[1] = 1'b0; vld[2] = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 38) begin
        chk("t2_even_par", dout[1], 1);
        chk("t2_odd_par", dout[2], 0);
      end
      if (k == 43) chk("t2_done43", done[1], 0);
      if (k == 44) begin
        chk("t2_done_even", done[1], 1);
        chk("t2_done_odd", done[2], 1);
      end
    end
    @(negedge clk);
    chk("t2_busy_fall", busy[1], 0);

    // 7N2 depth 4 burst with valid held high
    @(negedge clk);
    vld[3] = 1'b1; data[3] = w3[0]; n = 0; c = 0;
    while (n < 5 && c < 50) begin
      r = rdy[3];
      @(negedge clk);
      c++;
      if (r) begin n++; data[3] = w3[n]; end
    end
    chk("t3_accepted", n, 5);
    chk("t3_ready_low", rdy[3], 0);
    chk("t3_level_full", lv(3), 4);
    while (n < 6 && c < 300) begin
      r = rdy[3];
      @(negedge clk);
      c++;
      if (r) n++;
    end
    vld[3] = 1'b0;
    chk("t3_sixth", n, 6);
    wait_drain(3, 400);
    chk("t3_frames", rxn[3], 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t3_rx%0d", k), rxl[3][k], w3[k]);

    // enable gating
    en[0] = 1'b0;
    put(0, 9'h03C);
    put(0, 9'h0C3);
    repeat (5) @(negedge clk);
    chk("t4_hold_line", dout[0], 1);
    chk("t4_hold_level", lv(0), 2);
    en[0] = 1'b1;
    @(negedge clk);
    chk("t4_pop_busy", busy[0], 1);
    chk("t4_pop_line", dout[0], 0);
    chk("t4_pop_level", lv(0), 1);
    repeat (8) @(negedge clk);
    en[0] = 1'b0;
    repeat (40) @(negedge clk);
    chk("t4_wait_busy", busy[0], 0);
    chk("t4_wait_level", lv(0), 1);
    chk("t4_wait_line", dout[0], 1);
    en[0] = 1'b1;
    wait_drain(0, 200);
    chk("t4_rx_a", rxl[0][1], 9'h03C);
    chk("t4_rx_b", rxl[0][2], 9'h0C3);

    // reset mid-DATA with 3 words queued
    en[0] = 1'b0;
    put(0, 9'h011); put(0, 9'h022); put(0, 9'h033); put(0, 9'h044);
    en[0] = 1'b1;
    @(negedge clk);
    repeat (12) @(negedge clk);
    base = rxn[0];
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_rst_line", dout[0], 1);
    chk("t5_rst_level", lv(0), 0);
    chk("t5_rst_busy", busy[0], 0);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    chk("t5_after_busy", busy[0], 0);
    chk("t5_after_line", dout[0], 1);
    chk("t5_no_frames", rxn[0], base);

    // push coinciding with a pop at level 3
    en[0] = 1'b0;
    for (int k = 0; k < 4; k++) put(0, w6[k]);
    base = rxn[0];
    en[0] = 1'b1;
    @(negedge clk);
    chk("t6_level3", lv(0), 3);
    c = 0;
    while (done[0] !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t6_done_seen", done[0], 1);
    chk("t6_level_pre", lv(0), 3);
    vld[0] = 1'b1; data[0] = w6[4];
    @(negedge clk);
    vld[0] = 1'b0;
    chk("t6_level_same", lv(0), 3);
    chk("t6_restart_line", dout[0], 0);
    wait_drain(0, 400);
    chk("t6_frames", rxn[0] - base, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t6_rx%0d", k), rxl[0][base+k], w6[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Parametrised UART transmitter that supersedes the single-byte, edge-triggered transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, parity mode and stop-bit count are configurable, and queued words are sent back-to-back with no idle gap. It sits between the on-chip data source (e.g. the AES output or MRAM statistics logger) and the board TX pin.

Parameters:
CLOCK_FREQ, 50000000, uart_clock frequency in Hz
BAUD_RATE, 4000000, line rate; DIVISOR = CLOCK_FREQ/BAUD_RATE (integer division), must be >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, TX FIFO entries; power of 2, >= 2

Ports:
uart_clock  in  1  system clock
uart_reset  in  1  synchronous, active-low reset
uart_tx_enable  in  1  1 = may start new frames; 0 = hold after current frame
uart_tx_valid  in  1  source presents a word
uart_tx_data  in  DATA_BITS  word to transmit
uart_tx_ready  out  1  FIFO not full; write occurs when valid & ready
uart_d_out  out  1  serial line, idle high, registered
uart_busy  out  1  frame in progress (FSM not IDLE)
uart_tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit
uart_fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset: the reset is synchronous and active-low, with one clock: uart_clock and reset uart_reset. While uart_reset = 0 at a rising edge: uart_d_out = 1, uart_busy = 0, uart_tx_done = 0, uart_fifo_level = 0, uart_tx_ready = 1, FSM = IDLE, and all counters are cleared. Reset mid-frame aborts the frame, drives the line high on that edge and discards the FIFO contents.
- FIFO: uart_tx_ready = (level != FIFO_DEPTH), decoded from registered state with no combinational path from valid. A write while full is ignored and the data is lost; the source must honour ready. A simultaneous push and pop when not full leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Bit timing: each line symbol is held for exactly DIVISOR cycles (counter runs 0..DIVISOR-1).
- Frame length: (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * DIVISOR cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if uart_tx_enable = 1 and level > 0, pop the head word into the shift register and go to START. uart_d_out goes to 0 on that same edge.
  - START: line 0 for DIVISOR cycles, then go to DATA.
  - DATA: send bit[0] first, shifting right each period. After DATA_BITS periods go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: line = XOR of the data bits (even mode) or its inverse (odd mode), computed from the popped word. Hold for DIVISOR cycles, then go to STOP.
  - STOP: line 1 for STOP_BITS*DIVISOR cycles. On the final cycle, pulse uart_tx_done. If enable = 1 and level > 0, pop and go directly to START, so the next start bit follows the last stop bit with zero gap. Otherwise go to IDLE.
- Latency: a word written at edge N into an empty FIFO while IDLE and enabled is popped at edge N+1, and uart_d_out = 0 from edge N+1.
- Enable deasserted mid-frame: the current frame completes unchanged, and no further pops occur until enable returns to 1.
- uart_tx_data is sampled only on an accepted write. Changes at other times have no effect.
- uart_busy = 1 in START, DATA, PARITY and STOP.
- For DATA_BITS = 9 the parity bit covers all 9 data bits.

Test Plan:
(Bench parameters: CLOCK_FREQ = 40, BAUD_RATE = 10, so DIVISOR = 4.)
1. 8N1, write 0xA5 once -> uart_d_out sequence 0,1,0,1,0,0,1,0,1,1, each symbol held 4 cycles; done pulses at cycle 40 after the pop; busy falls the next cycle.
2. 8E1, write 0x07 -> parity bit = 1, frame 44 cycles; 8O1 with 0x07 -> parity bit = 0.
3. 7N2, FIFO_DEPTH = 4, burst of 6 writes with valid held high -> ready deasserts after 5 accepted words (1 popped + 4 queued); all 5 frames go out back-to-back with no high gap beyond the 2 stop bits; level falls 4 -> 0; the 6th word is sent once ready returns.
4. Enable = 0 with 2 words queued -> line stays 1 and level = 2; enable = 1 -> pop on the next edge. Deassert enable during the first frame -> that frame completes and the second waits.
5. Reset asserted mid-DATA of frame 1 with 3 words queued -> at that edge line = 1, level = 0, busy = 0; no further frames after reset release.
6. Simultaneous write and pop at level = 3 (depth 8) -> level stays 3 and data order is preserved (check by decoding the line with the bench receiver).
